// File: rtl/ethernet_udp_handler.sv
// UDP stage behind the IPv4 parser: parses the UDP header, verifies the checksum,
// forwards the payload with zero latency and emits one metadata record per datagram.
module ethernet_udp_handler #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_i,
  input  logic                  s_axis_tvalid_i,
  output logic                  s_axis_tready_o,
  input  logic                  s_axis_tlast_i,
  output logic [DATA_WIDTH-1:0] m_axis_tdata_o,
  output logic                  m_axis_tvalid_o,
  input  logic                  m_axis_tready_i,
  output logic                  m_axis_tlast_o,
  input  logic [31:0]           ip_src_ip_i,
  input  logic [31:0]           ip_dst_ip_i,
  output logic                  meta_valid_o,
  input  logic                  meta_ready_i,
  output logic [15:0]           meta_src_port_o,
  output logic [15:0]           meta_dst_port_o,
  output logic [15:0]           meta_length_o,
  output logic                  meta_csum_ok_o,
  output logic                  meta_len_err_o
);

  localparam int unsigned HDR_BYTES = 8;

  typedef enum logic [1:0] {S_HEADER, S_FORWARD, S_DRAIN, S_WAIT} state_e;

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [31:0] sum_q, sum_d;
  logic        odd_q, odd_d;
  logic [7:0]  hi_q, hi_d;
  logic        err_q, err_d;
  logic [15:0] src_q, src_d, dst_q, dst_d, len_q, len_d, rx_csum_q, rx_csum_d;

  logic        s_fire, hdr_fire, fwd_fire, last_pl;
  logic        to_wait, to_drain, to_fwd, csum_ok_c;
  logic [31:0] seed, fin_sum;
  logic [16:0] fold1;
  logic [15:0] fold2;

  assign s_fire   = s_axis_tvalid_i && s_axis_tready_o;
  assign hdr_fire = s_fire && (state_q == S_HEADER);
  assign fwd_fire = s_fire && (state_q == S_FORWARD);
  assign last_pl  = (cnt_q == len_q - 16'd1);

  // Payload path is a straight wire while forwarding.
  assign m_axis_tdata_o  = s_axis_tdata_i;
  assign m_axis_tvalid_o = (state_q == S_FORWARD) && s_axis_tvalid_i;
  assign m_axis_tlast_o  = (state_q == S_FORWARD) && (last_pl || s_axis_tlast_i);

  always_comb begin
    unique case (state_q)
      S_HEADER:  s_axis_tready_o = 1'b1;
      S_FORWARD: s_axis_tready_o = m_axis_tready_i;
      S_DRAIN:   s_axis_tready_o = 1'b1;
      default:   s_axis_tready_o = 1'b0;
    endcase
  end

  assign seed = {16'd0, ip_src_ip_i[31:16]} + {16'd0, ip_src_ip_i[15:0]}
              + {16'd0, ip_dst_ip_i[31:16]} + {16'd0, ip_dst_ip_i[15:0]} + 32'h0000_0011;

  // Header capture and running one's-complement sum over pseudo-header + datagram.
  always_comb begin
    sum_d     = sum_q;
    odd_d     = odd_q;
    hi_d      = hi_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    rx_csum_d = rx_csum_q;
    if (hdr_fire) begin
      if (cnt_q == 16'd0) sum_d = seed;
      unique case (cnt_q[2:0])
        3'd0: src_d[15:8]     = s_axis_tdata_i;
        3'd1: src_d[7:0]      = s_axis_tdata_i;
        3'd2: dst_d[15:8]     = s_axis_tdata_i;
        3'd3: dst_d[7:0]      = s_axis_tdata_i;
        3'd4: len_d[15:8]     = s_axis_tdata_i;
        3'd5: len_d[7:0]      = s_axis_tdata_i;
        3'd6: rx_csum_d[15:8] = s_axis_tdata_i;
        default: rx_csum_d[7:0] = s_axis_tdata_i;
      endcase
      if (cnt_q == 16'd5) sum_d = sum_d + {16'd0, len_q[15:8], s_axis_tdata_i};
    end
    if (hdr_fire || fwd_fire) begin
      if (odd_q) begin
        sum_d = sum_d + {16'd0, hi_q, s_axis_tdata_i};
        odd_d = 1'b0;
      end else begin
        hi_d  = s_axis_tdata_i;
        odd_d = 1'b1;
      end
    end
    fin_sum = sum_d + (odd_d ? {16'd0, hi_d, 8'h00} : 32'd0);
    fold1   = {1'b0, fin_sum[15:0]} + {1'b0, fin_sum[31:16]};
    fold2   = fold1[15:0] + {15'd0, fold1[16]};
  end

  // Framing decisions for the byte presented this cycle.
  always_comb begin
    to_wait  = 1'b0;
    to_drain = 1'b0;
    to_fwd   = 1'b0;
    err_d    = err_q;
    if (hdr_fire) begin
      if (cnt_q != 16'(HDR_BYTES - 1)) begin
        if (s_axis_tlast_i) begin
          err_d   = 1'b1;
          to_wait = 1'b1;
        end
      end else begin
        // A stream ending on the last header byte with payload still owed is truncated.
        if (len_d < 16'(HDR_BYTES) || (len_d > 16'(HDR_BYTES) && s_axis_tlast_i)) err_d = 1'b1;
        if (s_axis_tlast_i)                 to_wait  = 1'b1;
        else if (len_d <= 16'(HDR_BYTES))   to_drain = 1'b1;
        else                                to_fwd   = 1'b1;
      end
    end else if (fwd_fire) begin
      if (last_pl) begin
        if (s_axis_tlast_i) to_wait  = 1'b1;
        else                to_drain = 1'b1;
      end else if (s_axis_tlast_i) begin
        err_d   = 1'b1;
        to_wait = 1'b1;
      end
    end else if (s_fire && state_q == S_DRAIN && s_axis_tlast_i) begin
      to_wait = 1'b1;
    end
    csum_ok_c = !err_d && ((fold2 == 16'hFFFF) || (rx_csum_d == 16'h0000));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= S_HEADER;
      cnt_q           <= '0;
      sum_q           <= '0;
      odd_q           <= 1'b0;
      hi_q            <= '0;
      err_q           <= 1'b0;
      src_q           <= '0;
      dst_q           <= '0;
      len_q           <= '0;
      rx_csum_q       <= '0;
      meta_valid_o    <= 1'b0;
      meta_src_port_o <= '0;
      meta_dst_port_o <= '0;
      meta_length_o   <= '0;
      meta_csum_ok_o  <= 1'b0;
      meta_len_err_o  <= 1'b0;
    end else begin
      if (hdr_fire || fwd_fire) begin
        cnt_q     <= cnt_q + 16'd1;
        sum_q     <= sum_d;
        odd_q     <= odd_d;
        hi_q      <= hi_d;
        src_q     <= src_d;
        dst_q     <= dst_d;
        len_q     <= len_d;
        rx_csum_q <= rx_csum_d;
      end
      err_q <= err_d;
      unique case (state_q)
        S_WAIT: begin
          if (meta_ready_i) begin
            state_q      <= S_HEADER;
            meta_valid_o <= 1'b0;
            cnt_q        <= '0;
            sum_q        <= '0;
            odd_q        <= 1'b0;
            err_q        <= 1'b0;
          end
        end
        default: begin
          if (to_wait) begin
            state_q         <= S_WAIT;
            meta_valid_o    <= 1'b1;
            meta_src_port_o <= src_d;
            meta_dst_port_o <= dst_d;
            meta_length_o   <= len_d;
            meta_csum_ok_o  <= csum_ok_c;
            meta_len_err_o  <= err_d;
          end else if (to_drain) begin
            state_q <= S_DRAIN;
          end else if (to_fwd) begin
            state_q <= S_FORWARD;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ethernet_udp_handler.sv
// Scoreboard bench for ethernet_udp_handler: directed datagrams, expected payload
// beats and metadata records queued at stimulus time, popped by a monitor.
module tb_ethernet_udp_handler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_tdata;
  logic        s_tvalid, s_tready, s_tlast;
  logic [7:0]  m_tdata;
  logic        m_tvalid, m_tready, m_tlast;
  logic [31:0] src_ip, dst_ip;
  logic        meta_valid, meta_ready;
  logic [15:0] meta_src, meta_dst, meta_len;
  logic        meta_ok, meta_err;
  logic        toggle = 1'b0;

  typedef struct packed {
    logic [15:0] src;
    logic [15:0] dst;
    logic [15:0] len;
    logic        ok;
    logic        err;
  } meta_t;

  logic [8:0] pq[$];
  meta_t      mq[$];
  int checks = 0;
  int failures = 0;

  logic [7:0] f_good[$], f_bad[$], f_pad[$], f_short[$];

  always #5 clk = ~clk;

  ethernet_udp_handler #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata_i(s_tdata), .s_axis_tvalid_i(s_tvalid),
    .s_axis_tready_o(s_tready), .s_axis_tlast_i(s_tlast),
    .m_axis_tdata_o(m_tdata), .m_axis_tvalid_o(m_tvalid),
    .m_axis_tready_i(m_tready), .m_axis_tlast_o(m_tlast),
    .ip_src_ip_i(src_ip), .ip_dst_ip_i(dst_ip),
    .meta_valid_o(meta_valid), .meta_ready_i(meta_ready),
    .meta_src_port_o(meta_src), .meta_dst_port_o(meta_dst),
    .meta_length_o(meta_len), .meta_csum_ok_o(meta_ok),
    .meta_len_err_o(meta_err)
  );

  // Output backpressure: either always ready or alternating every cycle.
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1 m_tready = toggle ? ~m_tready : 1'b1;
    end
  end

  function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endfunction

  task automatic monitor();
    meta_t m;
    forever begin
      @(negedge clk);
      if (rst_n && m_tvalid && m_tready) begin
        if (pq.size() == 0) chk("payload_unexpected", {55'd0, m_tlast, m_tdata}, 64'h1_0000);
        else chk("payload_beat", {55'd0, m_tlast, m_tdata}, {55'd0, pq.pop_front()});
      end
      if (rst_n && meta_valid && meta_ready) begin
        m = '{meta_src, meta_dst, meta_len, meta_ok, meta_err};
        if (mq.size() == 0) chk("meta_unexpected", {14'd0, m}, 64'hFFFF_FFFF_FFFF);
        else chk("meta_record", {14'd0, m}, {14'd0, mq.pop_front()});
      end
    end
  endtask

  task automatic send(input logic [7:0] b[$], input int n);
    int w;
    for (int i = 0; i < n; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = b[i];
      s_tlast  = (i == b.size() - 1);
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!s_tready && w < 200);
      if (!s_tready) chk("send_timeout", 64'(w), 64'd0);
      @(posedge clk);
      #1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic push_payload(input logic [7:0] b[$], input int first, input int last);
    for (int i = first; i <= last; i++) pq.push_back({i == last, b[i]});
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((pq.size() != 0 || mq.size() != 0) && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk("idle_timeout", 64'(n >= 300), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    chk({tag, "_m_tvalid"}, 64'(m_tvalid), 64'd0);
    chk({tag, "_meta_valid"}, 64'(meta_valid), 64'd0);
    chk({tag, "_meta_fields"}, {14'd0, meta_src, meta_dst, meta_len, meta_ok, meta_err}, 64'd0);
    chk({tag, "_s_tready"}, 64'(s_tready), 64'd1);
  endtask

  initial begin
    int w;
    f_good  = '{8'h12, 8'h34, 8'h00, 8'h50, 8'h00, 8'h0C, 8'hCC, 8'h60, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    f_bad   = '{8'h12, 8'h34, 8'h00, 8'h50, 8'h00, 8'h0C, 8'hCC, 8'h61, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    f_pad   = '{8'h12, 8'h34, 8'h00, 8'h50, 8'h00, 8'h0C, 8'hCC, 8'h60, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
                8'h55, 8'h66};
    f_short = '{8'h12, 8'h34, 8'h00, 8'h50, 8'h00, 8'h10, 8'hCC, 8'h60, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    src_ip = 32'hC0A8_0101;
    dst_ip = 32'hC0A8_0102;
    s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
    meta_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    fork monitor(); join_none

    // 1: good checksum
    push_payload(f_good, 8, 11);
    mq.push_back('{16'h1234, 16'h0050, 16'h000C, 1'b1, 1'b0});
    send(f_good, f_good.size());
    wait_idle();

    // 2: corrupted checksum
    push_payload(f_bad, 8, 11);
    mq.push_back('{16'h1234, 16'h0050, 16'h000C, 1'b0, 1'b0});
    send(f_bad, f_bad.size());
    wait_idle();

    // 3: trailing pad bytes trimmed
    push_payload(f_pad, 8, 11);
    mq.push_back('{16'h1234, 16'h0050, 16'h000C, 1'b1, 1'b0});
    send(f_pad, f_pad.size());
    wait_idle();

    // 4: stream ends before the UDP length is reached
    push_payload(f_short, 8, 11);
    mq.push_back('{16'h1234, 16'h0050, 16'h0010, 1'b0, 1'b1});
    send(f_short, f_short.size());
    wait_idle();

    // 5: output backpressure and a stalled metadata consumer
    toggle = 1'b1;
    meta_ready = 1'b0;
    push_payload(f_good, 8, 11);
    mq.push_back('{16'h1234, 16'h0050, 16'h000C, 1'b1, 1'b0});
    send(f_good, f_good.size());
    w = 0;
    while (!meta_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("meta_valid_rise", 64'(meta_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("wait_meta_held", 64'(meta_valid), 64'd1);
      chk("wait_s_tready", 64'(s_tready), 64'd0);
    end
    chk("wait_payload_done", 64'(pq.size()), 64'd0);
    @(posedge clk);
    #1 meta_ready = 1'b1;
    wait_idle();
    toggle = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 6: reset mid-header abandons the datagram, then a clean resend
    send(f_good, 4);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("midreset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    push_payload(f_good, 8, 11);
    mq.push_back('{16'h1234, 16'h0050, 16'h000C, 1'b1, 1'b0});
    send(f_good, f_good.size());
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
